// File: rtl/vga_sync_monitor.sv
// Recovers x/y position from an observed VGA sync stream, locks onto it and
// flags sync/blanking timing violations with sticky error bits.
module vga_sync_monitor #(
    parameter int H_VIS    = 640,
    parameter int H_SYNC_S = 656,
    parameter int H_SYNC_E = 752,
    parameter int H_TOT    = 800,
    parameter int V_VIS    = 480,
    parameter int V_SYNC_S = 490,
    parameter int V_SYNC_E = 492,
    parameter int V_TOT    = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        video_on,
    input  logic        err_clr,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        locked,
    output logic        pix_valid,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        err_hsync,
    output logic        err_vsync,
    output logic        err_blank
);

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [9:0] HV    = 10'(H_VIS);
    localparam logic [9:0] HSS   = 10'(H_SYNC_S);
    localparam logic [9:0] HSE   = 10'(H_SYNC_E);
    localparam logic [9:0] HT_M1 = 10'(H_TOT - 1);
    localparam logic [9:0] VV    = 10'(V_VIS);
    localparam logic [9:0] VSS   = 10'(V_SYNC_S);
    localparam logic [9:0] VSE   = 10'(V_SYNC_E);
    localparam logic [9:0] VT_M1 = 10'(V_TOT - 1);

    logic        hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q, vo_s1_q, vo_s2_q;
    logic [1:0]  state_q, state_d;
    logic [9:0]  cx_q, cx_d, cy_q, cy_d;
    logic [9:0]  x_q, y_q;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        err_hsync_q, err_hsync_d;
    logic        err_vsync_q, err_vsync_d;
    logic        err_blank_q, err_blank_d;

    logic hs_fall, hs_rise, vs_fall, vs_rise;
    logic hs_viol, vs_viol, bl_viol, checking;

    // cx/cy track the newest sample (s1); x/y lag by one so they describe s2.
    always_comb begin
        hs_fall  = hs_s2_q & ~hs_s1_q;
        hs_rise  = ~hs_s2_q & hs_s1_q;
        vs_fall  = vs_s2_q & ~vs_s1_q;
        vs_rise  = ~vs_s2_q & vs_s1_q;
        checking = (state_q != SEARCH);
        hs_viol  = checking && ((hs_fall != (cx_q == HSS)) || (hs_rise != (cx_q == HSE)));
        vs_viol  = checking && ((vs_fall != (cx_q == 10'd0 && cy_q == VSS)) ||
                                (vs_rise != (cx_q == 10'd0 && cy_q == VSE)));
        bl_viol  = (state_q == LOCKED) && (vo_s2_q != ((x_q < HV) && (y_q < VV)));
    end

    always_comb begin
        state_d = state_q;
        if (cx_q == HT_M1) begin
            cx_d = 10'd0;
            cy_d = (cy_q == VT_M1) ? 10'd0 : cy_q + 10'd1;
        end else begin
            cx_d = cx_q + 10'd1;
            cy_d = cy_q;
        end
        case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d = ACQUIRE;
                    cx_d    = 10'd1;
                    cy_d    = VSS;
                end
            end
            ACQUIRE: begin
                if (hs_viol || vs_viol) state_d = SEARCH;
                else if (vs_fall)       state_d = LOCKED;
            end
            LOCKED: begin
                if (hs_viol || vs_viol) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
        if (state_d == SEARCH) begin
            cx_d = 10'd0;
            cy_d = 10'd0;
        end
        frame_start_d = (state_d == LOCKED) && (cx_q == 10'd0) && (cy_q == 10'd0);
        frame_count_d = frame_count_q + 16'(frame_start_d);
        // A violation on the same cycle as err_clr wins so the flag stays set.
        err_hsync_d = (err_hsync_q & ~err_clr) | hs_viol;
        err_vsync_d = (err_vsync_q & ~err_clr) | vs_viol;
        err_blank_d = (err_blank_q & ~err_clr) | bl_viol;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hs_s1_q       <= 1'b1;
            hs_s2_q       <= 1'b1;
            vs_s1_q       <= 1'b1;
            vs_s2_q       <= 1'b1;
            vo_s1_q       <= 1'b1;
            vo_s2_q       <= 1'b1;
            state_q       <= SEARCH;
            cx_q          <= 10'd0;
            cy_q          <= 10'd0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
            err_hsync_q   <= 1'b0;
            err_vsync_q   <= 1'b0;
            err_blank_q   <= 1'b0;
        end else begin
            hs_s1_q       <= hsync;
            hs_s2_q       <= hs_s1_q;
            vs_s1_q       <= vsync;
            vs_s2_q       <= vs_s1_q;
            vo_s1_q       <= video_on;
            vo_s2_q       <= vo_s1_q;
            state_q       <= state_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            x_q           <= cx_q;
            y_q           <= cy_q;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            err_hsync_q   <= err_hsync_d;
            err_vsync_q   <= err_vsync_d;
            err_blank_q   <= err_blank_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign locked      = (state_q == LOCKED);
    assign pix_valid   = (state_q == LOCKED) & vo_s2_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign err_hsync   = err_hsync_q;
    assign err_vsync   = err_vsync_q;
    assign err_blank   = err_blank_q;

endmodule
